// File: rtl/enemy_pkg.sv
// Shared enemy constants: FSM states, spawn point table, screen limits and sprite size.
// Pure definitions, so no latency or flow control applies.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REQ  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [8:0] SCREEN_X_MAX = 9'd319;
    localparam logic [8:0] SCREEN_Y_MAX = 9'd239;
    localparam logic [8:0] SPRITE_SIZE  = 9'd26;

    // Top-left corners of the four spawn points.
    localparam logic [8:0] SPAWN_X [4] = '{9'd4, 9'd290, 9'd4, 9'd290};
    localparam logic [8:0] SPAWN_Y [4] = '{9'd4, 9'd4, 9'd210, 9'd210};

    // Keeps a sprite's top-left corner far enough from the edge that the sprite stays on screen.
    function automatic logic [8:0] clamp_pos(input logic [8:0] pos, input logic [8:0] lim);
        logic [8:0] edge_pos;
        edge_pos = lim - SPRITE_SIZE + 9'd1;
        return (pos > edge_pos) ? edge_pos : pos;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns a slow frame clock into a single-cycle tick on its rising edge.
// Tick appears 2 clk cycles after the edge; free running, no backpressure.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= frame_clk;
            prev_q <= sync_q;
            tick   <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Enemy slot scheduler: spawns into the lowest free slot every interval frames, holds a request until spawn_ack.
// Kills shorten the interval per wave; SPAWN_LFSR_EN selects an LFSR spawn point instead of round-robin.
module enemy_spawn_ctrl
    import enemy_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SPAWN_INTERVAL = 120,
    parameter int MIN_INTERVAL   = 30,
    parameter int INTERVAL_STEP  = 8,
    parameter int KILLS_PER_WAVE = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic                 game_start,
    input  logic                 game_over,
    input  logic                 kill_valid,
    input  logic [2:0]           kill_slot,
    input  logic                 spawn_ack,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic [8:0]           spawn_x,
    output logic [8:0]           spawn_y,
    output logic [NUM_SLOTS-1:0] slot_alive,
    output logic [15:0]          kill_count,
    output logic [3:0]           wave
);

    localparam int CW = 16;
    localparam logic [CW-1:0] INT_INIT  = CW'(SPAWN_INTERVAL);
    localparam logic [CW-1:0] INT_MIN   = CW'(MIN_INTERVAL);
    localparam logic [CW-1:0] INT_STEP  = CW'(INTERVAL_STEP);
    localparam logic [7:0]    KPW_LAST  = 8'(KILLS_PER_WAVE - 1);

    state_t         state;
    logic [CW-1:0]  frame_cnt;
    logic [CW-1:0]  interval;
    logic [CW-1:0]  next_interval;
    logic [7:0]     wave_kills;
    logic           held;
    logic           tick;
    logic           active;
    logic           kill_hit;
    logic           free_any;
    logic           expired;
    logic [2:0]     free_slot;
    logic [1:0]     pt_idx;
    logic [NUM_SLOTS-1:0] kill_mask;
    logic [NUM_SLOTS-1:0] ack_mask;
    logic [NUM_SLOTS-1:0] alive_nxt;

    frame_tick_gen u_frame_tick (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Kills are qualified against the pre-update alive bits; free-slot search looks at post-update bits
    // so a freed slot can be requested in the same cycle it dies.
    always_comb begin
        kill_mask = '0;
        ack_mask  = '0;
        free_any  = 1'b0;
        free_slot = 3'd0;
        active    = (state == ST_RUN) || (state == ST_REQ);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active && kill_valid && (kill_slot == 3'(i)) && slot_alive[i])
                kill_mask[i] = 1'b1;
            if ((state == ST_REQ) && spawn_ack && (spawn_slot == 3'(i)))
                ack_mask[i] = 1'b1;
        end
        kill_hit  = |kill_mask;
        alive_nxt = (slot_alive & ~kill_mask) | ack_mask;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!alive_nxt[i]) begin
                free_any  = 1'b1;
                free_slot = 3'(i);
            end
        end
        expired       = frame_cnt >= (interval - 1'b1);
        next_interval = (interval >= INT_MIN + INT_STEP) ? (interval - INT_STEP) : INT_MIN;
    end

`ifdef SPAWN_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            lfsr <= 8'hA5;
        else if (tick)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign pt_idx = lfsr[1:0];
`else
    logic [1:0] sp_idx;
    logic       ack_fire;

    assign ack_fire = (state == ST_REQ) && spawn_ack && !game_over;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            sp_idx <= 2'd0;
        else if (ack_fire)
            sp_idx <= sp_idx + 2'd1;
    end

    assign pt_idx = sp_idx;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            interval    <= INT_INIT;
            wave_kills  <= '0;
            held        <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_slot  <= 3'd0;
            spawn_x     <= 9'd0;
            spawn_y     <= 9'd0;
            slot_alive  <= '0;
            kill_count  <= 16'd0;
            wave        <= 4'd0;
        end else if (game_over) begin
            state       <= ST_OVER;
            spawn_valid <= 1'b0;
            slot_alive  <= '0;
            held        <= 1'b0;
        end else begin
            if (kill_hit) begin
                if (kill_count != 16'hFFFF)
                    kill_count <= kill_count + 16'd1;
                if (wave_kills == KPW_LAST) begin
                    wave_kills <= '0;
                    interval   <= next_interval;
                    if (wave != 4'hF)
                        wave <= wave + 4'd1;
                end else begin
                    wave_kills <= wave_kills + 8'd1;
                end
            end
            if (active)
                slot_alive <= alive_nxt;

            case (state)
                ST_IDLE: begin
                    if (game_start) begin
                        state      <= ST_RUN;
                        frame_cnt  <= '0;
                        held       <= 1'b0;
                        kill_count <= 16'd0;
                        wave       <= 4'd0;
                        wave_kills <= '0;
                        interval   <= INT_INIT;
                    end
                end
                ST_RUN: begin
                    // held remembers an expiry that found every slot occupied
                    if ((tick && expired) || held) begin
                        if (free_any) begin
                            state       <= ST_REQ;
                            frame_cnt   <= '0;
                            held        <= 1'b0;
                            spawn_valid <= 1'b1;
                            spawn_slot  <= free_slot;
                            spawn_x     <= clamp_pos(SPAWN_X[pt_idx], SCREEN_X_MAX);
                            spawn_y     <= clamp_pos(SPAWN_Y[pt_idx], SCREEN_Y_MAX);
                        end else begin
                            held      <= 1'b1;
                            frame_cnt <= interval - 1'b1;
                        end
                    end else if (tick) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (tick && !expired)
                        frame_cnt <= frame_cnt + 1'b1;
                    if (spawn_ack) begin
                        spawn_valid <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed bench for enemy_spawn_ctrl with a queue of expected spawns and a small kill/wave model.
module tb_enemy_spawn_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic       kill_valid = 1'b0;
    logic [2:0] kill_slot = 3'd0;
    logic       spawn_ack = 1'b0;
    logic       spawn_valid;
    logic [2:0] spawn_slot;
    logic [8:0] spawn_x;
    logic [8:0] spawn_y;
    logic [3:0] slot_alive;
    logic [15:0] kill_count;
    logic [3:0] wave;

    typedef struct {
        int slot;
        int x;
        int y;
        int ticks;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   TX[4] = '{4, 290, 4, 290};
    int   TY[4] = '{4, 4, 210, 210};

    int         m_kills, m_wave, m_wk, m_interval, m_idx, m_req_slot;
    logic [3:0] m_alive;

    enemy_spawn_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .game_start  (game_start),
        .game_over   (game_over),
        .kill_valid  (kill_valid),
        .kill_slot   (kill_slot),
        .spawn_ack   (spawn_ack),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .slot_alive  (slot_alive),
        .kill_count  (kill_count),
        .wave        (wave)
    );

    always #10 Clk = ~Clk;

    initial begin
        repeat (80000) @(posedge Clk);
        $display("FAIL watchdog: observed no summary after 80000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kills = 0; m_wave = 0; m_wk = 0; m_interval = 120; m_idx = 0; m_req_slot = 0;
        m_alive = 4'b0000;
    endtask

    function automatic void push_spawn(input int ticks);
        exp_t e;
        e.slot = -1;
        for (int i = 3; i >= 0; i--)
            if (!m_alive[i]) e.slot = i;
        e.x = TX[m_idx];
        e.y = TY[m_idx];
        e.ticks = ticks;
        m_req_slot = e.slot;
        sb.push_back(e);
    endfunction

    // One frame_clk pulse, then wait until the tick has reached the FSM.
    task automatic do_tick();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_req(input string tag, input exp_t e);
        chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
        chk({tag, "_slot"}, 32'(spawn_slot), 32'(e.slot));
        chk({tag, "_x"}, 32'(spawn_x), 32'(e.x));
        chk({tag, "_y"}, 32'(spawn_y), 32'(e.y));
    endtask

    task automatic wait_spawn(input string tag);
        exp_t e;
        int   n;
        logic seen;
        e = sb.pop_front();
        n = 0;
        seen = 1'b0;
        while (!seen && n < e.ticks + 8) begin
            do_tick();
            n++;
            seen = spawn_valid;
        end
        chk({tag, "_ticks"}, 32'(n), 32'(e.ticks));
        check_req(tag, e);
    endtask

    task automatic step(input logic ack, input logic kv, input int ks);
        logic hit;
        hit = kv && (ks < 4) && m_alive[ks];
        spawn_ack  = ack;
        kill_valid = kv;
        kill_slot  = 3'(ks);
        @(negedge Clk);
        spawn_ack  = 1'b0;
        kill_valid = 1'b0;
        if (hit) begin
            m_alive[ks] = 1'b0;
            m_kills++;
            m_wk++;
            if (m_wk == 8) begin
                m_wk = 0;
                if (m_wave < 15) m_wave++;
                m_interval = (m_interval - 8 < 30) ? 30 : m_interval - 8;
            end
        end
        if (ack) begin
            m_alive[m_req_slot] = 1'b1;
            m_idx = (m_idx + 1) % 4;
        end
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic any_valid;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_slot", 32'(spawn_slot), 32'd0);
        chk("rst_x", 32'(spawn_x), 32'd0);
        chk("rst_y", 32'(spawn_y), 32'd0);
        chk("rst_alive", 32'(slot_alive), 32'd0);
        chk("rst_kills", 32'(kill_count), 32'd0);
        chk("rst_wave", 32'(wave), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // First spawn, then reset while the request is pending.
        pulse_start();
        push_spawn(120);
        wait_spawn("t1_pre");
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("t1_rst_valid", 32'(spawn_valid), 32'd0);
        chk("t1_rst_alive", 32'(slot_alive), 32'd0);
        model_reset();
        Reset_n = 1'b1;
        @(negedge Clk);
        pulse_start();
        push_spawn(120);
        wait_spawn("t1");
        step(1'b1, 1'b0, 0);
        chk("t1_ack_valid", 32'(spawn_valid), 32'd0);
        chk("t1_alive", 32'(slot_alive), 32'(m_alive));

        // Fill the remaining slots, then run a full interval with nothing free.
        for (int i = 1; i < 4; i++) begin
            push_spawn(120);
            wait_spawn("t2_fill");
            step(1'b1, 1'b0, 0);
        end
        chk("t2_full", 32'(slot_alive), 32'hF);
        any_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            do_tick();
            any_valid = any_valid | spawn_valid;
        end
        chk("t2_hold_novalid", 32'(any_valid), 32'd0);
        step(1'b0, 1'b1, 2);
        push_spawn(0);
        e = sb.pop_front();
        check_req("t2_free", e);
        step(1'b1, 1'b0, 0);
        chk("t2_kills", 32'(kill_count), 32'(m_kills));

        // Kill everything, then cycle spawn/kill until wave 12.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i);
        chk("t3_alive0", 32'(slot_alive), 32'd0);
        while (m_wave < 12) begin
            push_spawn(m_interval);
            wait_spawn("t3");
            step(1'b1, 1'b0, 0);
            step(1'b0, 1'b1, m_req_slot);
            if (m_kills == 8) begin
                chk("t3_kc8", 32'(kill_count), 32'd8);
                chk("t3_wave1", 32'(wave), 32'd1);
            end
        end
        chk("t3_wave12", 32'(wave), 32'd12);
        chk("t3_kills", 32'(kill_count), 32'(m_kills));
        push_spawn(m_interval);
        wait_spawn("t3_floor");
        step(1'b1, 1'b0, 0);

        // Kill on a dead slot is ignored.
        chk("t4_alive_pre", 32'(slot_alive), 32'b0001);
        step(1'b0, 1'b1, 1);
        chk("t4_kills", 32'(kill_count), 32'(m_kills));
        chk("t4_wave", 32'(wave), 32'(m_wave));
        chk("t4_alive", 32'(slot_alive), 32'b0001);

        // Ack and kill in the same cycle.
        step(1'b0, 1'b1, 0);
        push_spawn(m_interval);
        wait_spawn("t5_a");
        step(1'b1, 1'b0, 0);
        push_spawn(m_interval);
        wait_spawn("t5_b");
        step(1'b1, 1'b0, 0);
        chk("t5_alive11", 32'(slot_alive), 32'b0011);
        step(1'b0, 1'b1, 0);
        push_spawn(m_interval);
        wait_spawn("t5_c");
        step(1'b1, 1'b1, 1);
        chk("t5_alive01", 32'(slot_alive), 32'b0001);
        chk("t5_kills", 32'(kill_count), 32'(m_kills));

        // game_over while a request is pending.
        push_spawn(m_interval);
        wait_spawn("t6");
        game_over = 1'b1;
        @(negedge Clk);
        chk("t6_valid", 32'(spawn_valid), 32'd0);
        chk("t6_alive", 32'(slot_alive), 32'd0);
        @(negedge Clk);
        game_over = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t6_kills_held", 32'(kill_count), 32'(m_kills));
        chk("t6_wave_held", 32'(wave), 32'(m_wave));
        any_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            do_tick();
            any_valid = any_valid | spawn_valid;
        end
        chk("t6_idle_novalid", 32'(any_valid), 32'd0);
        chk("t6_idle_kills", 32'(kill_count), 32'(m_kills));
        pulse_start();
        chk("t6_start_kills", 32'(kill_count), 32'd0);
        chk("t6_start_wave", 32'(wave), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enemy_spawn_ctrl.md
Name: enemy_spawn_ctrl

Overview:
Scheduler that allocates and recycles the enemy instance slots in the boxhead game. Decides when a new enemy appears, which free slot it uses, and at which spawn point. Tracks kills and shortens the spawn interval as kills accumulate. Sits between the game-state logic and the array of enemy sprite/motion blocks. Each enemy block is re-initialised through this block's spawn handshake.

Parameters:
NUM_SLOTS, 4, number of enemy instances managed (2..8)
SPAWN_INTERVAL, 120, initial frames between spawns
MIN_INTERVAL, 30, floor for the spawn interval
INTERVAL_STEP, 8, frames removed from the interval per wave
KILLS_PER_WAVE, 8, kills that advance the wave

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  ~60 Hz frame clock, sampled on Clk
game_start  in  1  one-cycle pulse that leaves IDLE
game_over  in  1  level; forces OVER
kill_valid  in  1  one-cycle kill report
kill_slot  in  3  slot being killed (upper bits ignored beyond NUM_SLOTS)
spawn_ack  in  1  enemy block accepted the spawn
spawn_valid  out  1  spawn request pending
spawn_slot  out  3  slot to (re)initialise
spawn_x  out  9  spawn X, top-left, 0..319
spawn_y  out  9  spawn Y, top-left, 0..239
slot_alive  out  NUM_SLOTS  per-slot enable to the enemy blocks
kill_count  out  16  total kills, saturating
wave  out  4  current wave, saturating at 15

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; frame counter 0; interval=SPAWN_INTERVAL; spawn point index 0.
- Frame tick: one-cycle pulse on a frame_clk rising edge. Detect it with a two-register delay on Clk. Tick latency is 2 Clk cycles after the edge.
- FSM states: IDLE, RUN, REQ, OVER.
  - IDLE -> RUN on game_start. Frame counter cleared.
  - RUN: the frame counter increments on each tick. When counter == interval-1 on a tick and at least one slot is free: counter <= 0, go to REQ.
  - RUN, all slots alive: the counter holds at interval-1. REQ is entered on the first cycle a slot frees, with no extra tick.
  - REQ: spawn_valid=1. spawn_slot is the lowest-index free slot, latched on entry. spawn_x/y come from the spawn point table entry, latched on entry. All are stable until ack.
  - On spawn_ack in REQ: slot_alive[spawn_slot] <= 1, spawn point index +1 mod 4, spawn_valid <= 0 next cycle, go to RUN. The counter keeps running during REQ.
  - Any state -> OVER when game_over=1 (priority over everything except reset). OVER drops spawn_valid and clears slot_alive. OVER -> IDLE when game_over deasserts. kill_count and wave are held in OVER and cleared on IDLE -> RUN.
- Kill: when kill_valid and slot_alive[kill_slot] are both 1, in RUN or REQ:
  - clear the alive bit;
  - kill_count +1, saturating at 0xFFFF;
  - per-wave counter +1; at KILLS_PER_WAVE it wraps to 0, wave +1 (sat 15), and interval = max(interval-INTERVAL_STEP, MIN_INTERVAL).
- A kill on a dead or out-of-range slot is ignored entirely.
- Kill and ack on the same cycle: both apply. Alive update = (alive & ~kill_mask) | ack_mask. The kill is qualified by pre-update alive, so a kill cannot target the slot being spawned.
- The new interval takes effect on the next comparison. If the counter is already >= the new interval-1, REQ fires on the next tick.
- Spawn table (package constant, top-left): (4,4), (290,4), (4,210), (290,210).

Optional Feature:
SPAWN_LFSR_EN:
- Defined: the spawn point index is the 2 LSBs of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset). The LFSR steps on every frame tick.
- Undefined: round-robin index as above; no LFSR logic is present.

Decomposition:
- Package enemy_pkg holds:
  - typedef enum for the FSM states;
  - SPAWN_X/SPAWN_Y constant arrays [4];
  - screen limits 319/239;
  - sprite size 26.
- Sub-module frame_tick_gen: frame_clk edge detect, outputs the tick pulse. It is reused by player and enemy blocks.
- The lowest-free-slot priority encoder stays inline.

Test Plan:
1. Reset mid-REQ, then game_start and 120 ticks -> spawn_valid=1, spawn_slot=0, (4,4). Ack -> slot_alive=4'b0001.
2. Four spawns with immediate ack, then 120 more ticks -> no spawn_valid and counter held. Kill slot 2 -> spawn_valid next cycle, spawn_slot=2, (4,4), index wrapped.
3. 8 valid kills -> kill_count=8, wave=1, interval=112. 12 waves -> interval floors at 30.
4. kill_valid on a dead slot 1 -> kill_count, wave and alive unchanged.
5. Same-cycle spawn_ack (slot 0) and kill (slot 1, alive) -> alive=...01, kill_count+1.
6. game_over in REQ -> spawn_valid=0 and slot_alive=0 next cycle. Release -> IDLE, kill_count held until game_start.
